// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command framer.
//   HDR_BIT    : bit position of the header flag in a received byte
//   PAYLOAD_W  : width of the assembled command word
//   FIELD_W    : payload bits carried by each received byte
//   state_e    : framer states
//   OP_*       : opcode values found in cmd_data[20:19] (decoded downstream)
package uart_cmd_pkg;

    localparam int unsigned HDR_BIT   = 7;
    localparam int unsigned PAYLOAD_W = 21;
    localparam int unsigned FIELD_W   = 7;

    typedef enum logic [1:0] {
        IDLE,
        GOT1,
        GOT2,
        HOLD
    } state_e;

    localparam logic [1:0] OP_OFFSET  = 2'b00;
    localparam logic [1:0] OP_DIVISOR = 2'b01;
    localparam logic [1:0] OP_COUNT   = 2'b10;
    localparam logic [1:0] OP_EXT     = 2'b11;

endpackage

// File: rtl/uart_cmd_framer_frame_timer.sv
// Inter-byte timeout counter for the command framer.
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   clear_i  : force the count to zero this cycle (has priority)
//   enable_i : count while set
//   expire_o : count has reached TIMEOUT_CYCLES-1 in an enabled, uncleared cycle
module frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TIMER_WIDTH    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [TIMER_WIDTH-1:0] LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMER_WIDTH-1:0] count_q;
    logic [TIMER_WIDTH-1:0] count_d;

    // A clear in the terminal cycle suppresses expiry: an accepted byte wins.
    assign expire_o = enable_i && !clear_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear_i || expire_o) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_cmd_framer.sv
// Assembles 3-byte UART command frames (header bit7=1, two data bytes bit7=0)
// into one 21-bit word {hdr[6:0], b1[6:0], b2[6:0]} held on a valid/ready port.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   in_data   : received byte          in_valid  : byte available
//   in_ready  : byte accepted this cycle when in_valid is also high
//   cmd_data  : assembled payload      cmd_valid : payload held
//   cmd_ready : downstream consumes the payload
//   err_count : saturating framing-error count
//   err_pulse : one-cycle pulse per framing error
module uart_cmd_framer
    import uart_cmd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TIMER_WIDTH    = 16,
    parameter int unsigned ERR_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [PAYLOAD_W-1:0]  cmd_data,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic                  err_pulse
);

    state_e                   state_q;
    logic [2*FIELD_W-1:0]     payload_q;   // {hdr, b1} of the frame in progress
    logic [PAYLOAD_W-1:0]     cmd_data_q;
    logic                     cmd_valid_q;
    logic [ERR_WIDTH-1:0]     err_count_q;
    logic                     err_pulse_q;

    logic                     accept;
    logic                     is_hdr;
    logic                     busy;
    logic                     expire;
    logic                     err_event;
    logic [FIELD_W-1:0]       field;

    assign in_ready  = (state_q != HOLD);
    assign accept    = in_valid && in_ready;
    assign is_hdr    = in_data[DATA_WIDTH-1];
    assign field     = in_data[FIELD_W-1:0];
    assign busy      = (state_q == GOT1) || (state_q == GOT2);

    assign cmd_data  = cmd_data_q;
    assign cmd_valid = cmd_valid_q;
    assign err_count = err_count_q;
    assign err_pulse = err_pulse_q;

    frame_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMER_WIDTH    (TIMER_WIDTH)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (accept || !busy),
        .enable_i (busy),
        .expire_o (expire)
    );

    // Error sources are mutually exclusive: expiry implies no accepted byte.
    always_comb begin
        err_event = 1'b0;
        if (expire) begin
            err_event = 1'b1;
        end else if (accept) begin
            case (state_q)
                IDLE:       err_event = !is_hdr;
                GOT1, GOT2: err_event = is_hdr;
                default:    err_event = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            payload_q   <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= err_event;
            if (err_event && (err_count_q != '1)) begin
                err_count_q <= err_count_q + 1'b1;
            end

            if (expire) begin
                state_q   <= IDLE;
                payload_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept && is_hdr) begin
                            payload_q[FIELD_W +: FIELD_W] <= field;
                            state_q                       <= GOT1;
                        end
                    end
                    GOT1: begin
                        if (accept) begin
                            if (is_hdr) begin
                                payload_q[FIELD_W +: FIELD_W] <= field;
                            end else begin
                                payload_q[0 +: FIELD_W] <= field;
                                state_q                 <= GOT2;
                            end
                        end
                    end
                    GOT2: begin
                        if (accept) begin
                            if (is_hdr) begin
                                payload_q[FIELD_W +: FIELD_W] <= field;
                                state_q                       <= GOT1;
                            end else begin
                                cmd_data_q  <= {payload_q, field};
                                cmd_valid_q <= 1'b1;
                                state_q     <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (cmd_ready) begin
                            cmd_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Randomised and directed bench for uart_cmd_framer with a frame-level
// reference model and a queue-based scoreboard.
module tb_uart_cmd_framer;
    import uart_cmd_pkg::*;

    localparam int unsigned T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [20:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [7:0]  err_count;
    logic        err_pulse;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic rand_rdy = 1'b0;
    logic rdy_force = 1'b1;
    int pulse_cnt = 0;
    int pulse_base = 0;

    // Reference model state: partial frame fields, expected frames, error tally.
    logic [FIELD_W-1:0] part[$];
    logic [20:0]        exp_q[$];
    int last_acc = 0;
    int model_err = 0;

    logic [1:0] ops[4] = '{OP_OFFSET, OP_DIVISOR, OP_COUNT, OP_EXT};

    uart_cmd_framer #(
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (T),
        .TIMER_WIDTH    (16),
        .ERR_WIDTH      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .err_count (err_count),
        .err_pulse (err_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) cmd_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // A partial frame is lost once T whole cycles pass with no accepted byte.
    task automatic model_timeout(input int now);
        if (part.size() != 0 && (now - last_acc - 1) >= int'(T)) begin
            model_err++;
            part.delete();
        end
    endtask

    task automatic model_accept(input logic [7:0] b, input int now);
        model_timeout(now);
        last_acc = now;
        if (b[HDR_BIT]) begin
            if (part.size() != 0) model_err++;
            part.delete();
            part.push_back(b[FIELD_W-1:0]);
        end else if (part.size() == 0) begin
            model_err++;
        end else begin
            part.push_back(b[FIELD_W-1:0]);
            if (part.size() == 3) begin
                exp_q.push_back({part[0], part[1], part[2]});
                part.delete();
            end
        end
    endtask

    task automatic model_reset();
        part.delete();
        exp_q.delete();
        model_err  = 0;
        pulse_base = pulse_cnt;
    endtask

    // Monitor: scoreboard pops on each handshake, plus HOLD-phase invariants.
    logic        prev_stall = 1'b0;
    logic [20:0] prev_data = '0;
    always @(negedge clk) begin
        #4;
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (err_pulse) pulse_cnt++;
            if (cmd_valid) check("in_ready_low_in_hold", in_ready, 0);
            if (prev_stall) begin
                check("hold_valid", cmd_valid, 1);
                check("hold_data_stable", cmd_data, prev_data);
            end
            if (cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: got 0x%0h expected none", cmd_data);
                end else begin
                    check("frame", cmd_data, exp_q.pop_front());
                end
            end
            prev_stall = cmd_valid && !cmd_ready;
            prev_data  = cmd_data;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_wait: in_ready got 0 expected 1 for byte 0x%02h", b);
            in_valid = 1'b0;
            return;
        end
        model_accept(b, cyc);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic checkpoint(input string name, input int exp_errs);
        logic [7:0] ec;
        int sat;
        rand_rdy  = 1'b0;
        rdy_force = 1'b1;
        idle(4);
        model_timeout(cyc);
        ec = err_count;
        idle(1);
        sat = (model_err > 255) ? 255 : model_err;
        check({name, "_err_count"}, ec, sat);
        check({name, "_pulses"}, pulse_cnt - pulse_base, model_err);
        check({name, "_drained"}, exp_q.size(), 0);
        if (exp_errs >= 0) check({name, "_err_count_abs"}, ec, exp_errs);
    endtask

    task automatic reset_check(input string name);
        rst = 1'b0;
        #1;
        check({name, "_in_ready"}, in_ready, 1);
        check({name, "_cmd_valid"}, cmd_valid, 0);
        check({name, "_cmd_data"}, cmd_data, 0);
        check({name, "_err_count"}, err_count, 0);
        check({name, "_err_pulse"}, err_pulse, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int g;

        idle(3);
        reset_check("reset");

        // Single clean frame with downstream always ready.
        send(8'h85); send(8'h12); send(8'h34);
        check("t1_latency_valid", cmd_valid, 1);
        check("t1_data", cmd_data, 21'h014934);
        @(negedge clk);
        check("t1_valid_one_cycle", cmd_valid, 0);
        checkpoint("t1", 0);

        // Stray data byte in IDLE, then a clean frame.
        send(8'h12);
        send(8'h85); send(8'h12); send(8'h34);
        checkpoint("t2", 1);

        // Header inside a frame restarts it.
        send(8'h85); send(8'h90); send(8'h01); send(8'h02);
        check("t3_valid", cmd_valid, 1);
        check("t3_data", cmd_data, 21'h040082);
        checkpoint("t3", 2);

        // Back-pressure: next frame offered while the first is held.
        rdy_force = 1'b0;
        send(8'h85); send(8'h12); send(8'h34);
        fork
            begin
                send(8'h81); send(8'h01); send(8'h01);
            end
            begin
                idle(10);
                check("t4_held_data", cmd_data, 21'h014934);
                check("t4_in_ready_low", in_ready, 0);
                rdy_force = 1'b1;
            end
        join
        checkpoint("t4", 2);

        // Timeout of a partial frame, then a stray byte.
        send(8'h85);
        idle(T + 1);
        checkpoint("t5_timeout", 3);
        send(8'h12);
        checkpoint("t5_stray", 4);

        // A byte arriving in the last allowed cycle keeps the frame alive.
        send(8'h85); idle(T - 1); send(8'h12); idle(T - 1); send(8'h34);
        checkpoint("t5_boundary", 4);

        // Randomised traffic against the model with random back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T - 2, T + 2))
                                            : int'($urandom_range(0, 2));
            idle(g);
            if ($urandom_range(0, 2) == 0) b = {1'b1, ops[$urandom_range(0, 3)], 5'($urandom)};
            else                           b = {1'b0, 7'($urandom)};
            send(b);
        end
        checkpoint("rand", -1);

        // Saturation of the error counter from a known zero.
        reset_check("reset2");
        for (int i = 0; i < 300; i++) send({1'b0, 7'($urandom_range(0, 127))});
        checkpoint("sat", 255);

        // Reset while in GOT2 drops the partial frame.
        send(8'h85); send(8'h12);
        reset_check("reset_got2");
        send(8'h81); send(8'h01); send(8'h01);
        checkpoint("post_reset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
